// File: rtl/de_converter_pkg.sv
// de_converter_pkg: shared widths, loop length and FSM states for the DBNS converter
package de_converter_pkg;
  localparam int TERM_W = 8;
  localparam int A_W = 4;
  localparam int B_W = 3;
  localparam int DATA_W = 16;
  localparam int MUL_CYCLES = 7;
  typedef enum logic [1:0] {LOAD, MUL, ACC} state_t;
endpackage

// File: rtl/dbns_term_eval.sv
// dbns_term_eval: builds 3^b by repeated x3 steps, then emits the valid-gated 2^a shift
module dbns_term_eval
  import de_converter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [B_W-1:0]    cnt,
  input  logic [TERM_W-1:0] term,
  output logic [DATA_W-1:0] val
);
  logic [DATA_W-1:0] acc;
  logic [A_W-1:0] a;
  logic [B_W-1:0] b;
  assign a = term[B_W+A_W-1:B_W];
  assign b = term[B_W-1:0];
  always_ff @(posedge clk or negedge rst)
    if (!rst) acc <= '0;
    else if (load) acc <= DATA_W'(1);
    else if (step && cnt < b) acc <= acc + (acc << 1);
  assign val = term[TERM_W-1] ? acc << a : '0;
endmodule

// File: rtl/de_converter.sv
// de_converter: free-running 9-cycle DBNS-to-binary converter (LOAD, 7x MUL, ACC)
module de_converter
  import de_converter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] REGA,
  output logic [DATA_W-1:0] REGC
);
  state_t state;
  logic [B_W-1:0] cnt;
  logic [DATA_W-1:0] opnd;
  logic [DATA_W-1:0] v1, v0;
  logic load, step;
  assign load = state == LOAD;
  assign step = state == MUL;
  dbns_term_eval u_t1 (.clk(clk), .rst(rst), .load(load), .step(step), .cnt(cnt),
                       .term(opnd[DATA_W-1:TERM_W]), .val(v1));
  dbns_term_eval u_t0 (.clk(clk), .rst(rst), .load(load), .step(step), .cnt(cnt),
                       .term(opnd[TERM_W-1:0]), .val(v0));
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= LOAD;
      cnt <= '0;
      opnd <= '0;
      REGC <= '0;
    end else begin
      case (state)
        LOAD: begin
          opnd <= REGA;
          cnt <= '0;
          state <= MUL;
        end
        MUL: begin
          cnt <= cnt + 1'b1;
          state <= cnt == B_W'(MUL_CYCLES - 1) ? ACC : MUL;
        end
        ACC: begin
          REGC <= v1 + v0;
          state <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
endmodule

// File: tb/tb_de_converter.sv
// tb_de_converter: directed and random operands checked against an arithmetic DBNS model
module tb_de_converter;
  logic clk, rst;
  logic [15:0] REGA, REGC;
  logic [15:0] last;
  int vectors = 0;
  int miscompares = 0;

  de_converter dut (.clk(clk), .rst(rst), .REGA(REGA), .REGC(REGC));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] model(input logic [15:0] op);
    longint sum = 0;
    for (int t = 0; t < 2; t++) begin
      logic [7:0] tm;
      longint p;
      tm = t ? op[15:8] : op[7:0];
      p = longint'(1) << tm[6:3];
      for (int k = 0; k < int'(tm[2:0]); k++) p = p * 3;
      if (tm[7]) sum += p;
    end
    return 16'(sum % 65536);
  endfunction

  task automatic check(input string tag, input logic [15:0] exp);
    vectors++;
    assert (REGC === exp) else begin
      miscompares++;
      $error("FAIL %s: REGC=%h expected %h", tag, REGC, exp);
    end
  endtask

  // Called with the next rising edge being a LOAD edge; returns one negedge after ACC.
  task automatic conv(input logic [15:0] op, input int chg_at, input logic [15:0] op2,
                      input string tag);
    REGA = op;
    for (int e = 1; e <= 9; e++) begin
      @(negedge clk);
      if (e == chg_at) REGA = op2;
      if (e < 9) check({tag, "_hold"}, last);
    end
    last = model(op);
    check(tag, last);
  endtask

  initial begin
    rst = 0;
    REGA = 16'h0;
    last = 16'h0;
    repeat (2) @(negedge clk);
    check("reset", 16'h0000);
    @(negedge clk);
    rst = 1;
    conv(16'h1ED2, 0, 16'h0, "case1");
    check("case1_val", 16'd9216);
    conv(16'h1ED2, 0, 16'h0, "case1_repeat");
    conv(16'h8B89, 0, 16'h0, "case2");
    check("case2_val", 16'd60);
    conv(16'h8080, 0, 16'h0, "case3a");
    check("case3a_val", 16'd2);
    conv(16'h0000, 0, 16'h0, "case3b");
    conv(16'hFFFF, 0, 16'h0, "case4");
    check("case4_val", 16'h0000);
    conv(16'h8080, 3, 16'h8B89, "case5a");
    check("case5a_val", 16'd2);
    conv(16'h8B89, 0, 16'h0, "case5b");
    check("case5b_val", 16'd60);
    REGA = 16'h8080;
    repeat (3) @(negedge clk);
    check("case6_pre", 16'd60);
    #1 rst = 0;
    #1 check("case6_async", 16'h0000);
    last = 16'h0;
    @(negedge clk);
    check("case6_held", 16'h0000);
    rst = 1;
    conv(16'h8080, 0, 16'h0, "case6_after");
    for (int i = 0; i < 24; i++)
      conv(16'($urandom), int'($urandom_range(0, 8)), 16'($urandom), "rand");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
